ic_number_to_hex: RTL and testbench
===================================

// Module: ic_number_to_hex
// PURPOSE
//  Converts a binary IC part number (0..9999) into four 7-segment digit codes
//  (HEX3 = thousands .. HEX0 = units). This is the inverse of the HEX-to-number decode path.
//  It drives the board displays with the IC number chosen by the tester, e.g. a database lookup.
//  Conversion is iterative double-dabble: start/done handshake, fixed latency.
// PARAMETERS
//  BLANK_LEADING   0  1: leading zero digits blanked (units digit never blanked)
//  SEG_ACTIVE_LOW  1  1: segment code bit=0 lights the segment; 0: all HEX outputs inverted
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous active-low reset
//  number     in   32  binary IC number, sampled only on an accepted load
//  load       in   1   start request, accepted when busy=0
//  HEX0       out  7   units digit code, bit order {g,f,e,d,c,b,a}
//  HEX1       out  7   tens digit code
//  HEX2       out  7   hundreds digit code
//  HEX3       out  7   thousands digit code
//  busy       out  1   conversion in progress
//  hex_valid  out  1   one-cycle pulse when HEX0..3 updated
//  overflow   out  1   last accepted number > 9999; held until next accepted load
// BEHAVIOUR
//  Reset (async, reset_n=0): HEX0..3 = blank (7'b1111111 active-low).
//   busy=0, hex_valid=0, overflow=0, FSM=IDLE, BCD shift register cleared.
//  Digit codes (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//   5=0010010 6=0000010 7=1111000 8=0000000 9=0011000.
//   Blank=1111111, dash=0111111 (g only). SEG_ACTIVE_LOW=0 inverts every code.
//  FSM: IDLE -> SHIFT -> ENCODE -> IDLE.
//  IDLE: load=1 at edge E0 captures number.
//   If number>9999: overflow<=1, shift reg <= 0. Else overflow<=0, shift reg <= number[13:0].
//   busy<=1, count<=0, go to SHIFT.
//  SHIFT: edges E1..E14, one bit per edge. Each BCD nibble >=5 gets +3, then {bcd,bin} <<= 1.
//   count increments each edge; exit to ENCODE after the 14th shift (count==13 at that edge).
//  ENCODE: at edge E15, HEX0..3 are registered from the BCD nibbles.
//   If overflow=1, all four show dash instead.
//   BLANK_LEADING=1: a digit is blanked when it and all higher digits are 0 (HEX0 never blanked).
//   At the same edge: hex_valid<=1 for exactly one cycle, busy<=0, go to IDLE.
//  Latency fixed at 15 cycles from load edge to hex_valid, overflow included.
//  Throughput: a new load is accepted in the cycle after hex_valid.
//  load while busy=1 is ignored; number changes while busy do not affect the result.
//  HEX0..3 and overflow hold their values between conversions.
//   They change only at an ENCODE edge, or at load for overflow.
//  Nibble values never exceed 9 after correction; any nibble >9 at ENCODE shows dash (defensive).
//  Reset mid-conversion aborts immediately: outputs go to reset values, with no hex_valid pulse.
// TESTING
//  Reset, release, idle 5 cycles -> HEX0..3=1111111, busy=0, hex_valid=0, overflow=0.
//  load with number=7400 -> busy for 15 cycles, one hex_valid pulse.
//   HEX3=1111000, HEX2=0011001, HEX1=1000000, HEX0=1000000.
//  number=9999 then number=10000 -> first all 0011000, overflow=0.
//   Second: all 0111111, overflow=1, same 15-cycle latency.
//  load=7400, then at cycle 5 load=4011 with a new number -> second load ignored.
//   Result is 7400; a load after hex_valid then converts 4011.
//  BLANK_LEADING=1: number=74 -> HEX3=HEX2=1111111, HEX1=1111000, HEX0=0011001.
//   number=0 -> HEX3..1 blank, HEX0=1000000.
//  Assert reset_n=0 at cycle 8 of a conversion -> immediate blank outputs, busy=0.
//   No hex_valid pulse; the next load converts correctly.

Source files
------------

// File: rtl/ic_number_to_hex.sv
// Binary IC part number (0..9999) to four 7-segment digit codes.
// Iterative double-dabble conversion with a load/busy/hex_valid handshake and a fixed 15-cycle latency.
module ic_number_to_hex #(
    parameter bit BLANK_LEADING  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] number,
    input  logic        load,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        busy,
    output logic        hex_valid,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Segment codes are built active-low and flipped once at the output stage
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0011000;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    function automatic logic [6:0] polarity(input logic [6:0] c);
        polarity = SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        bcd_adjust = r;
    endfunction

    state_t      state, next_state;
    logic [3:0]  count;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [6:0]  enc [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = SHIFT;
            SHIFT:   if (count == 4'd13) next_state = ENCODE;
            ENCODE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bcd_adj = bcd_adjust(bcd);

    // Leading-zero blanking: a digit blanks only if it and every higher digit is zero
    always_comb begin
        logic z3, z2, z1;
        z3 = (bcd[15:12] == 4'd0);
        z2 = z3 && (bcd[11:8] == 4'd0);
        z1 = z2 && (bcd[7:4] == 4'd0);
        enc[0] = seg_code(bcd[3:0]);
        enc[1] = (BLANK_LEADING && z1) ? SEG_BLANK : seg_code(bcd[7:4]);
        enc[2] = (BLANK_LEADING && z2) ? SEG_BLANK : seg_code(bcd[11:8]);
        enc[3] = (BLANK_LEADING && z3) ? SEG_BLANK : seg_code(bcd[15:12]);
        if (overflow) begin
            for (int i = 0; i < 4; i++) enc[i] = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HEX0      <= polarity(SEG_BLANK);
            HEX1      <= polarity(SEG_BLANK);
            HEX2      <= polarity(SEG_BLANK);
            HEX3      <= polarity(SEG_BLANK);
            busy      <= 1'b0;
            hex_valid <= 1'b0;
            overflow  <= 1'b0;
            count     <= 4'd0;
            bin       <= 14'd0;
            bcd       <= 16'd0;
        end else begin
            hex_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        overflow <= (number > 32'd9999);
                        bin      <= (number > 32'd9999) ? 14'd0 : number[13:0];
                        bcd      <= 16'd0;
                        busy     <= 1'b1;
                        count    <= 4'd0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    count      <= count + 4'd1;
                end
                ENCODE: begin
                    HEX0      <= polarity(enc[0]);
                    HEX1      <= polarity(enc[1]);
                    HEX2      <= polarity(enc[2]);
                    HEX3      <= polarity(enc[3]);
                    hex_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_number_to_hex.sv
// Bench for ic_number_to_hex: plain, leading-blank and inverted-polarity instances driven in parallel.
module tb_ic_number_to_hex;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] number;
    logic        load;

    logic [6:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;
    logic       busy, hex_valid, overflow;
    logic       b_busy, b_valid, b_ovf, c_busy, c_valid, c_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ic_number_to_hex #(.BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .number(number), .load(load),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3),
        .busy(busy), .hex_valid(hex_valid), .overflow(overflow));

    ic_number_to_hex #(.BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_blank (
        .clk(clk), .reset_n(reset_n), .number(number), .load(load),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3),
        .busy(b_busy), .hex_valid(b_valid), .overflow(b_ovf));

    ic_number_to_hex #(.BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_inv (
        .clk(clk), .reset_n(reset_n), .number(number), .load(load),
        .HEX0(c0), .HEX1(c1), .HEX2(c2), .HEX3(c3),
        .busy(c_busy), .hex_valid(c_valid), .overflow(c_ovf));

    localparam logic [27:0] ALL_BLANK = {4{7'b1111111}};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: decimal digits by division, active-low codes from a lookup table
    function automatic logic [27:0] model_hex(input logic [31:0] n, input bit blank);
        logic [6:0] tbl [10];
        logic [27:0] r;
        int unsigned p;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (n > 32'd9999)
                r[i*7 +: 7] = 7'b0111111;
            else if (blank && i > 0 && n < p)
                r[i*7 +: 7] = 7'b1111111;
            else
                r[i*7 +: 7] = tbl[(n / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk_all(input string nm, input logic [31:0] n);
        chk({nm, "_plain"}, {4'd0, a3, a2, a1, a0},  {4'd0, model_hex(n, 1'b0)});
        chk({nm, "_blank"}, {4'd0, b3, b2, b1, b0},  {4'd0, model_hex(n, 1'b1)});
        chk({nm, "_inv"},   {4'd0, c3, c2, c1, c0},  {4'd0, ~model_hex(n, 1'b0)});
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after hex_valid
    task automatic run_conv(input logic [31:0] n, input int inject_at, input logic [31:0] inj_num);
        int lat;
        int busy_cyc;
        lat = 0;
        busy_cyc = 0;
        number = n;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        number = $urandom;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        chk("ovf_at_load", {31'd0, overflow}, {31'd0, n > 32'd9999});
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (hex_valid) begin
                lat = c;
                break;
            end
            if (busy) busy_cyc++;
            if (c == inject_at) begin
                load = 1'b1;
                number = inj_num;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        chk("latency", lat, 32'd15);
        chk("busy_cycles", busy_cyc, 32'd14);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("overflow", {31'd0, overflow}, {31'd0, n > 32'd9999});
        chk("valid_blank", {31'd0, b_valid}, 32'd1);
        chk_all("hex", n);
        number = $urandom;
        @(posedge clk); #1;
        chk("valid_one_cycle", {31'd0, hex_valid}, 32'd0);
        chk_all("hex_hold", n);
    endtask

    typedef struct {
        logic [31:0] num;
        logic [27:0] plain;
        logic [27:0] blank;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];
    int   pulses;
    logic [31:0] rn;

    initial begin
        vecs[0] = '{32'd7400, {7'b1111000, 7'b0011001, 7'b1000000, 7'b1000000},
                              {7'b1111000, 7'b0011001, 7'b1000000, 7'b1000000}, 1'b0};
        vecs[1] = '{32'd9999, {4{7'b0011000}}, {4{7'b0011000}}, 1'b0};
        vecs[2] = '{32'd10000, {4{7'b0111111}}, {4{7'b0111111}}, 1'b1};
        vecs[3] = '{32'd74, {7'b1000000, 7'b1000000, 7'b1111000, 7'b0011001},
                            {7'b1111111, 7'b1111111, 7'b1111000, 7'b0011001}, 1'b0};
        vecs[4] = '{32'd0, {4{7'b1000000}},
                           {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 1'b0};
        vecs[5] = '{32'd1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001},
                              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, {4{7'b0111111}}, {4{7'b0111111}}, 1'b1};

        reset_n = 1'b0;
        load = 1'b0;
        number = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_hex_plain", {4'd0, a3, a2, a1, a0}, {4'd0, ALL_BLANK});
        chk("rst_hex_inv",   {4'd0, c3, c2, c1, c0}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_valid",     {31'd0, hex_valid}, 32'd0);
        chk("rst_ovf",       {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].num, 0, 0);
            chk("tbl_plain", {4'd0, a3, a2, a1, a0}, {4'd0, vecs[i].plain});
            chk("tbl_blank", {4'd0, b3, b2, b1, b0}, {4'd0, vecs[i].blank});
            chk("tbl_ovf",   {31'd0, overflow}, {31'd0, vecs[i].ovf});
        end

        // Load while busy is ignored; the following load converts the new value
        run_conv(32'd7400, 5, 32'd4011);
        chk("ignored_load", {4'd0, a3, a2, a1, a0}, {4'd0, vecs[0].plain});
        run_conv(32'd4011, 0, 0);

        // Reset mid-conversion of an overflowing number
        number = 32'd10000;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ovf_before_abort", {31'd0, overflow}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_hex_plain", {4'd0, a3, a2, a1, a0}, {4'd0, ALL_BLANK});
        chk("abort_hex_blank", {4'd0, b3, b2, b1, b0}, {4'd0, ALL_BLANK});
        chk("abort_hex_inv",   {4'd0, c3, c2, c1, c0}, 32'd0);
        chk("abort_busy",      {31'd0, busy}, 32'd0);
        chk("abort_valid",     {31'd0, hex_valid}, 32'd0);
        chk("abort_ovf",       {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (hex_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        run_conv(32'd1234, 0, 0);

        // Randomized conversions, mostly in range with some overflow values
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) rn = 32'd10000 + $urandom_range(0, 100000);
            else                           rn = $urandom_range(0, 9999);
            run_conv(rn, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
